dispatch_queue: RTL and testbench

Parametrised DEPTH-entry circular FIFO of `ooop_types::rename_pkt_t` between rename and dispatch. It generalises the 1-entry dispatch buffer to arbitrary power-of-two depth. It adds occupancy, almost-full and credit outputs so rename can throttle ahead of full. It keeps the same valid/ready semantics and a single-cycle flush that drops all buffered entries.

---
 rtl/dispatch_queue_pkg.sv | 12 +
 rtl/ooop_types.sv | 18 +
 rtl/ooop_wrap_ptr.sv | 23 ++
 rtl/dispatch_queue.sv | 116 +++++++++++
 tb/tb_dispatch_queue.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/dispatch_queue_pkg.sv
// Dispatch queue configuration constants and elaboration helpers.
package dispatch_queue_pkg;

    // Queue depth used by the top-level core instantiation.
    localparam int unsigned DISPATCH_Q_DEPTH = 4;

    // True when v is a non-zero power of two.
    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/ooop_types.sv
// Shared out-of-order pipeline types: the rename-to-dispatch packet payload.
package ooop_types;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned ROB_W  = 6;
    localparam int unsigned PREG_W = 7;

    // Renamed micro-op as handed from rename to dispatch.
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [ROB_W-1:0]  rob_idx;
        logic [PREG_W-1:0] pdst;
        logic [PREG_W-1:0] psrc1;
        logic [PREG_W-1:0] psrc2;
        logic              has_dst;
    } rename_pkt_t;

endpackage

// File: rtl/ooop_wrap_ptr.sv
// Circular-buffer pointer: IW index bits plus one wrap bit above them.
module ooop_wrap_ptr #(
    parameter int unsigned IW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [IW:0]   ptr
);

    localparam int unsigned PW = IW + 1;

    // Increment wraps the index naturally and toggles the wrap bit; clear wins.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + PW'(1);
        end
    end

endmodule

// File: rtl/dispatch_queue.sv
// DEPTH-entry circular FIFO between rename and dispatch with occupancy,
// credit and almost-full feedback so rename can throttle ahead of full.
module dispatch_queue
    import ooop_types::*;
    import dispatch_queue_pkg::*;
#(
    parameter  int unsigned DEPTH     = DISPATCH_Q_DEPTH,
    parameter  int unsigned AF_THRESH = DEPTH - 1,
    localparam int unsigned CW        = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  rename_pkt_t       in_pkt,
    output logic              out_valid,
    input  logic              out_ready,
    output rename_pkt_t       out_pkt,
    output logic [CW-1:0]     count_o,
    output logic [CW-1:0]     credits_o,
    output logic              almost_full_o,
    output logic              empty_o
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = IW + 1;

    // Reject illegal configurations at elaboration time.
    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
        $error("dispatch_queue: DEPTH must be a power of two and at least 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_thresh
        $error("dispatch_queue: AF_THRESH must lie in 1..DEPTH");
    end

    rename_pkt_t       mem [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic              full;
    logic              do_push;
    logic              do_pop;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_nxt;
    logic [CW-1:0]     credits_q;
    logic              af_q;
    logic              empty_q;

    ooop_wrap_ptr #(.IW(IW)) u_head (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush_i),
        .inc   (do_pop),
        .ptr   (head)
    );

    ooop_wrap_ptr #(.IW(IW)) u_tail (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush_i),
        .inc   (do_push),
        .ptr   (tail)
    );

    // Full/empty from pointer compare; push may ride a same-cycle pop when full.
    assign full      = (head[IW-1:0] == tail[IW-1:0]) && (head[IW] != tail[IW]);
    assign out_valid = (head != tail);
    assign do_pop    = out_valid && out_ready;
    assign in_ready  = !full || do_pop;
    assign do_push   = in_valid && in_ready;
    assign out_pkt   = mem[head[IW-1:0]];

    // Storage: clear every slot on reset/flush, otherwise write at tail.
    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[tail[IW-1:0]] <= in_pkt;
        end
    end

    // Next occupancy: flush empties, push/pop move by one, both cancel.
    always_comb begin
        count_nxt = count_q;
        if (flush_i) begin
            count_nxt = '0;
        end else if (do_push && !do_pop) begin
            count_nxt = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_nxt = count_q - CW'(1);
        end
    end

    // Registered occupancy and the status outputs derived from it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q   <= '0;
            credits_q <= CW'(DEPTH);
            af_q      <= 1'b0;
            empty_q   <= 1'b1;
        end else begin
            count_q   <= count_nxt;
            credits_q <= CW'(DEPTH) - count_nxt;
            af_q      <= (count_nxt >= CW'(AF_THRESH));
            empty_q   <= (count_nxt == '0);
        end
    end

    assign count_o       = count_q;
    assign credits_o     = credits_q;
    assign almost_full_o = af_q;
    assign empty_o       = empty_q;

endmodule

// File: tb/tb_dispatch_queue.sv
// Randomised and directed bench for dispatch_queue against a queue-based model.
module tb_dispatch_queue;
    import ooop_types::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AF    = 3;
    localparam int unsigned CW    = 3;

    logic          clk;
    logic          rst_n;
    logic          flush_i;
    logic          in_valid;
    logic          in_ready;
    rename_pkt_t   in_pkt;
    logic          out_valid;
    logic          out_ready;
    rename_pkt_t   out_pkt;
    logic [CW-1:0] count_o;
    logic [CW-1:0] credits_o;
    logic          almost_full_o;
    logic          empty_o;

    int            total = 0;
    int            bad   = 0;
    rename_pkt_t   model_q[$];
    bit            cleared;
    rename_pkt_t   pk [16];

    dispatch_queue #(.DEPTH(DEPTH), .AF_THRESH(AF)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush_i),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pkt        (in_pkt),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pkt       (out_pkt),
        .count_o       (count_o),
        .credits_o     (credits_o),
        .almost_full_o (almost_full_o),
        .empty_o       (empty_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic rename_pkt_t mk_pkt();
        return rename_pkt_t'(32'($urandom) | 32'h1);
    endfunction

    // Compare registered outputs against the model's queue contents.
    task automatic check_state();
        int n;
        n = model_q.size();
        check("out_valid", 32'(out_valid),     32'(n != 0));
        check("count",     32'(count_o),       32'(n));
        check("credits",   32'(credits_o),     32'(int'(DEPTH) - n));
        check("af",        32'(almost_full_o), 32'(n >= int'(AF)));
        check("empty",     32'(empty_o),       32'(n == 0));
        if (n > 0) begin
            check("out_pkt", 32'(out_pkt), 32'(model_q[0]));
        end else if (cleared) begin
            check("out_pkt_clr", 32'(out_pkt), 32'h0);
        end
    endtask

    // One clock: drive inputs, check in_ready, advance model, check outputs.
    task automatic step(input logic v, input rename_pkt_t p, input logic r,
                        input logic f, input logic rn);
        bit exp_ready;
        bit push;
        bit pop;
        int n;
        in_valid  = v;
        in_pkt    = p;
        out_ready = r;
        flush_i   = f;
        rst_n     = rn;
        #1;
        n         = model_q.size();
        pop       = (n > 0) && r;
        exp_ready = (n < int'(DEPTH)) || pop;
        push      = v && exp_ready;
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        @(posedge clk);
        if (!rn || f) begin
            model_q.delete();
            cleared = 1;
        end else begin
            if (pop) model_q.delete(0);
            if (push) begin
                model_q.push_back(p);
                cleared = 0;
            end
        end
        @(negedge clk);
        check_state();
    endtask

    initial begin
        clk       = 0;
        rst_n     = 0;
        flush_i   = 0;
        in_valid  = 0;
        out_ready = 0;
        in_pkt    = '0;
        cleared   = 1;
        for (int i = 0; i < 16; i++) pk[i] = mk_pkt();

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        #1;
        check("rst_in_ready", 32'(in_ready),  32'h1);
        check("rst_credits",  32'(credits_o), 32'(DEPTH));
        check("rst_out_pkt",  32'(out_pkt),   32'h0);
        check_state();

        // Fill A..D, then a fifth push that must be refused.
        for (int i = 0; i < 4; i++) step(1'b1, pk[i], 1'b0, 1'b0, 1'b1);
        check("full_af", 32'(almost_full_o), 32'h1);
        step(1'b1, pk[5], 1'b0, 1'b0, 1'b1);

        // Full: pop A and push E in the same cycle, then drain B,C,D,E.
        step(1'b1, pk[4], 1'b1, 1'b0, 1'b1);
        check("full_swap_cnt", 32'(count_o), 32'd4);
        check("full_swap_head", 32'(out_pkt), 32'(pk[1]));
        for (int i = 0; i < 4; i++) step(1'b0, pk[15], 1'b1, 1'b0, 1'b1);

        // Continuous streaming across several wraps.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, pk[6 + (i % 10)], 1'b1, 1'b0, 1'b1);
            check("stream_cnt_le1", 32'(count_o <= CW'(1)), 32'h1);
        end
        repeat (2) step(1'b0, pk[15], 1'b1, 1'b0, 1'b1);

        // Flush at count 3 with simultaneous push and pop.
        for (int i = 0; i < 3; i++) step(1'b1, pk[i], 1'b0, 1'b0, 1'b1);
        step(1'b1, pk[9], 1'b1, 1'b1, 1'b1);
        check("flush_out_pkt", 32'(out_pkt), 32'h0);
        repeat (2) step(1'b0, pk[15], 1'b1, 1'b0, 1'b1);

        // Reset mid-operation with count 2, then a fresh push.
        for (int i = 0; i < 2; i++) step(1'b1, pk[i + 3], 1'b0, 1'b0, 1'b1);
        step(1'b1, pk[8], 1'b1, 1'b0, 1'b0);
        check("rst_mid_cnt", 32'(count_o), 32'h0);
        step(1'b1, pk[7], 1'b0, 1'b0, 1'b1);
        check("rst_mid_push", 32'(out_pkt), 32'(pk[7]));

        // Random traffic with phases of varying drain rate.
        for (int c = 0; c < 600; c++) begin
            int  rp;
            logic v;
            logic r;
            logic f;
            logic rn;
            rp = ((c / 50) % 3 == 0) ? 30 : (((c / 50) % 3 == 1) ? 60 : 90);
            v  = ($urandom_range(0, 99) < 70);
            r  = ($urandom_range(0, 99) < rp);
            f  = ($urandom_range(0, 99) < 3);
            rn = !($urandom_range(0, 199) == 0);
            step(v, mk_pkt(), r, f, rn);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
